// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
// The round-robin search function doubles as the reference ordering rule.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;

  // Requester index width, never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // First valid index searching last+1, last+2, ... modulo nreq; 0 when none valid.
  function automatic int unsigned rr_next(input logic [RR_MAX_REQ-1:0] valid,
                                          input int unsigned           last,
                                          input int unsigned           nreq);
    int unsigned idx;
    int unsigned pick;
    pick = 0;
    for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
      if (k < int'(nreq)) begin
        idx = last + 1 + unsigned'(k);
        if (idx >= nreq) idx = idx - nreq;
        if (valid[idx[RR_IDX_W-1:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: next requester after last_id with valid set.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last_id,
  output logic [IDW-1:0]  pick_id,
  output logic            pick_vld
);

  always_comb begin
    pick_vld = |req_valid;
    pick_id  = IDW'(rr_next(RR_MAX_REQ'(req_valid), 32'(last_id), NREQ));
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// Define FIFO_ARB_TAG_EN to prepend the owner index to wdata as a source tag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ      = 4,
  parameter  int unsigned DSIZE     = 8,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned IDW       = id_width(NREQ),
`ifdef FIFO_ARB_TAG_EN
  localparam int unsigned WW        = IDW + DSIZE,
`else
  localparam int unsigned WW        = DSIZE,
`endif
  localparam int unsigned CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [WW-1:0]         wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0]   pick_id;
  logic             pick_vld;
  logic [DSIZE-1:0] req_data_arr [NREQ];
  logic             own_vld;
  logic [DSIZE-1:0] own_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_data_arr[i] = req_data[i*DSIZE +: DSIZE];
  end

  assign own_vld  = req_valid[owner_q];
  assign own_data = req_data_arr[owner_q];

  fifo_arb_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_valid (req_valid),
    .last_id   (last_id_q),
    .pick_id   (pick_id),
    .pick_vld  (pick_vld)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      last_id_q  <= IDW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Outputs follow the owner combinationally so a full FIFO blocks winc in the same cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    winc       = 1'b0;
    wdata      = '0;
    grant_id   = '0;
    busy       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          owner_d    = pick_id;
          beat_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        busy               = 1'b1;
        grant_id           = owner_q;
        req_ready[owner_q] = ~wfull;
        winc               = own_vld & ~wfull;
`ifdef FIFO_ARB_TAG_EN
        wdata              = {owner_q, own_data};
`else
        wdata              = own_data;
`endif
        if (winc) beat_cnt_d = beat_cnt_q + CW'(1);
        // Release on a completed burst or when the owner goes idle, even while stalled.
        if ((winc && (beat_cnt_q == CW'(MAX_BURST - 1))) || !own_vld) begin
          state_d    = ARB_IDLE;
          last_id_d  = owner_q;
          beat_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned DSIZE     = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned IDW       = 2;
`ifdef FIFO_ARB_TAG_EN
  localparam int unsigned WW        = IDW + DSIZE;
`else
  localparam int unsigned WW        = DSIZE;
`endif
  localparam int unsigned OBW       = 1 + IDW + 1 + NREQ + WW;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [WW-1:0]         wdata;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rem [NREQ];
  int seq [NREQ];
  logic [OBW-1:0] obs, exp_v;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Requester i sends byte {i, seq} so source and order are visible in wdata.
  function automatic logic [WW-1:0] wd(input int id, input int s);
    logic [DSIZE-1:0] d;
    d = 8'(id * 16 + s);
`ifdef FIFO_ARB_TAG_EN
    return {2'(id), d};
`else
    return d;
`endif
  endfunction

  function automatic logic [OBW-1:0] exp_grant(input int id, input int s, input bit rdy, input bit wi);
    logic [NREQ-1:0] r;
    r = rdy ? 4'(1 << id) : 4'b0;
    return {1'b1, 2'(id), wi, r, wd(id, s)};
  endfunction

  function automatic logic [OBW-1:0] exp_idle();
    return '0;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]            = (rem[i] > 0);
      req_data[i*DSIZE +: DSIZE] = 8'(i * 16 + seq[i]);
    end
  endtask

  // Record this cycle's transfers, cross the edge, then present the next beat.
  task automatic advance();
    logic [NREQ-1:0] x;
    x = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (x[i]) begin
        seq[i]++;
        rem[i]--;
      end
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    drive_reqs();
    wrst_n = 1'b0;
    @(posedge wclk);
    #1;
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    drive_reqs();
    wrst_n = 1'b0;
    #2;
    obs = {busy, grant_id, winc, req_ready, wdata};
    n_tests++;
    if (obs !== exp_idle()) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, exp_idle());
    end
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    rem[1] = 8;
    rem[3] = 8;
    drive_reqs();
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk);
      exp_v = (c == 0) ? exp_idle() : exp_grant(1, c - 1, 1'b1, 1'b1);
      obs = {busy, grant_id, winc, req_ready, wdata};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_preburst cyc %0d: got %h expected %h", c, obs, exp_v);
      end
      if (c < 2) advance();
    end
    #2;
    wrst_n = 1'b0;
    #1;
    obs = {busy, grant_id, winc, req_ready, wdata};
    n_tests++;
    if (obs !== exp_idle()) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", obs, exp_idle());
    end
    @(negedge wclk);
    obs = {busy, grant_id, winc, req_ready, wdata};
    n_tests++;
    if (obs !== exp_idle()) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, exp_idle());
    end
    rem[0] = 8;
    rem[2] = 8;
    drive_reqs();
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk);
      exp_v = (c == 0) ? exp_idle() : exp_grant(0, 0, 1'b1, 1'b1);
      obs = {busy, grant_id, winc, req_ready, wdata};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_regrant cyc %0d: got %h expected %h", c, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int id;
    do_reset();
    for (int i = 0; i < NREQ; i++) rem[i] = 100;
    drive_reqs();
    for (int g = 0; g < 5; g++) begin
      id = g % NREQ;
      for (int b = -1; b < int'(MAX_BURST); b++) begin
        @(negedge wclk);
        exp_v = (b < 0) ? exp_idle() : exp_grant(id, (g / NREQ) * 4 + b, 1'b1, 1'b1);
        obs = {busy, grant_id, winc, req_ready, wdata};
        n_tests++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL round_robin grant %0d beat %0d: got %h expected %h", g, b, obs, exp_v);
        end
        advance();
      end
    end
  endtask

  task automatic test_single_req();
    int nb;
    do_reset();
    rem[2] = 10;
    drive_reqs();
    for (int g = 0; g < 3; g++) begin
      nb = (g < 2) ? 4 : 2;
      for (int b = -1; b < nb; b++) begin
        @(negedge wclk);
        exp_v = (b < 0) ? exp_idle() : exp_grant(2, g * 4 + b, 1'b1, 1'b1);
        obs = {busy, grant_id, winc, req_ready, wdata};
        n_tests++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL single_req grant %0d beat %0d: got %h expected %h", g, b, obs, exp_v);
        end
        advance();
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk);
      exp_v = (c == 0) ? exp_grant(2, 10, 1'b1, 1'b0) : exp_idle();
      obs = {busy, grant_id, winc, req_ready, wdata};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_req_release cyc %0d: got %h expected %h", c, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_wfull_stall();
    do_reset();
    rem[1] = 4;
    drive_reqs();
    for (int c = 0; c < 12; c++) begin
      wfull = (c >= 3 && c <= 7);
      @(negedge wclk);
      case (c)
        0:                exp_v = exp_idle();
        1:                exp_v = exp_grant(1, 0, 1'b1, 1'b1);
        2:                exp_v = exp_grant(1, 1, 1'b1, 1'b1);
        3, 4, 5, 6, 7:    exp_v = exp_grant(1, 2, 1'b0, 1'b0);
        8:                exp_v = exp_grant(1, 2, 1'b1, 1'b1);
        9:                exp_v = exp_grant(1, 3, 1'b1, 1'b1);
        default:          exp_v = exp_idle();
      endcase
      obs = {busy, grant_id, winc, req_ready, wdata};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL wfull_stall cyc %0d: got %h expected %h", c, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_drop_while_full();
    do_reset();
    rem[0] = 5;
    rem[1] = 3;
    drive_reqs();
    for (int c = 0; c < 8; c++) begin
      wfull = (c >= 2 && c <= 5);
      if (c == 3) begin
        rem[0] = 0;
        drive_reqs();
      end
      @(negedge wclk);
      case (c)
        0:       exp_v = exp_idle();
        1:       exp_v = exp_grant(0, 0, 1'b1, 1'b1);
        2, 3:    exp_v = exp_grant(0, 1, 1'b0, 1'b0);
        4:       exp_v = exp_idle();
        5:       exp_v = exp_grant(1, 0, 1'b0, 1'b0);
        6:       exp_v = exp_grant(1, 0, 1'b1, 1'b1);
        default: exp_v = exp_grant(1, 1, 1'b1, 1'b1);
      endcase
      obs = {busy, grant_id, winc, req_ready, wdata};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL drop_while_full cyc %0d: got %h expected %h", c, obs, exp_v);
      end
      advance();
    end
  endtask

`ifdef FIFO_ARB_TAG_EN
  task automatic test_tag();
    logic [WW-1:0] want;
    want = 10'b11_1010_0101;
    do_reset();
    rem[3] = 1;
    drive_reqs();
    req_data[3*DSIZE +: DSIZE] = 8'hA5;
    @(negedge wclk);
    advance();
    req_data[3*DSIZE +: DSIZE] = 8'hA5;
    @(negedge wclk);
    n_tests++;
    if (wdata !== want || winc !== 1'b1) begin
      n_fail++;
      $display("FAIL tag_wdata: got winc=%b wdata=%b expected winc=1 wdata=%b", winc, wdata, want);
    end
    advance();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wrst_n    = 1'b0;
    wfull     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_round_robin();
    test_single_req();
    test_wfull_stall();
    test_drop_while_full();
`ifdef FIFO_ARB_TAG_EN
    test_tag();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
